// File: rtl/sprite_redraw.sv
// Erase-then-redraw engine for the player, bullet and enemy sprites.
// Services move pulses in priority order and streams one VGA pixel write per clock.
module sprite_redraw #(
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] PLAYER_COLOUR = 3'b010,
   parameter logic [2:0] BULLET_COLOUR = 3'b111,
   parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
   parameter logic [7:0] SCREEN_W      = 8'd160,
   parameter logic [6:0] SCREEN_H      = 7'd120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear_all,
   input  logic       p_move,
   input  logic [7:0] p_x,
   input  logic [6:0] p_y,
   input  logic       b_move,
   input  logic [7:0] b_x,
   input  logic [6:0] b_y,
   input  logic       e_move,
   input  logic [7:0] e_x,
   input  logic [6:0] e_y,
   input  logic [3:0] e_width,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic       busy
);

   localparam int unsigned XW  = 8;
   localparam int unsigned YW  = 7;
   localparam int unsigned WW  = 4;
   localparam int unsigned CW  = 3;
   localparam int unsigned NCH = 3;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ERASE, S_DRAW} state_e;

   state_e          state_q, state_d;
   logic [NCH-1:0]  pending_q, pending_d;
   logic [1:0]      sel_q, sel_d;
   logic [XW-1:0]   ox_q, ox_d, nx_q, nx_d;
   logic [YW-1:0]   oy_q, oy_d, ny_q, ny_d;
   logic [WW-1:0]   ow_q, ow_d, nw_q, nw_d;
   logic [WW-1:0]   dx_q, dx_d, dy_q, dy_d;
   logic [XW-1:0]   old_x_q [NCH];
   logic [XW-1:0]   old_x_d [NCH];
   logic [YW-1:0]   old_y_q [NCH];
   logic [YW-1:0]   old_y_d [NCH];
   logic [WW-1:0]   old_w_q [NCH];
   logic [WW-1:0]   old_w_d [NCH];
   logic [NCH-1:0]  move_vec;
   logic            shadow_wr;

   logic [XW-1:0]   vga_x_q, vga_x_d;
   logic [YW-1:0]   vga_y_q, vga_y_d;
   logic [CW-1:0]   colour_q, colour_d;
   logic            plot_q, plot_d;
   logic            busy_q, busy_d;
   logic [XW:0]     sx;
   logic [YW:0]     sy;
   logic            pix_on;

   assign move_vec = {e_move, b_move, p_move};

   // Sequencing, pending-bit bookkeeping and shadow updates
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | move_vec;
      sel_d     = sel_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      ow_d      = ow_q;
      nx_d      = nx_q;
      ny_d      = ny_q;
      nw_d      = nw_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      old_x_d   = old_x_q;
      old_y_d   = old_y_q;
      old_w_d   = old_w_q;
      shadow_wr = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               state_d = S_LOAD;
               if (pending_q[0])      sel_d = 2'd0;
               else if (pending_q[1]) sel_d = 2'd1;
               else                   sel_d = 2'd2;
               // a pulse landing on the same edge re-arms the channel
               pending_d[sel_d] = move_vec[sel_d];
            end
         end
         S_LOAD: begin
            case (sel_q)
               2'd0: begin nx_d = p_x; ny_d = p_y; nw_d = 4'd3; end
               2'd1: begin nx_d = b_x; ny_d = b_y; nw_d = 4'd1; end
               default: begin nx_d = e_x; ny_d = e_y; nw_d = e_width; end
            endcase
            ox_d = old_x_q[sel_q];
            oy_d = old_y_q[sel_q];
            ow_d = old_w_q[sel_q];
            dx_d = '0;
            dy_d = '0;
            if (ow_d != '0)      state_d = S_ERASE;
            else if (nw_d != '0) state_d = S_DRAW;
            else begin
               state_d   = S_IDLE;
               shadow_wr = 1'b1;
            end
         end
         S_ERASE: begin
            if (dx_q == ow_q - 4'd1) begin
               dx_d = '0;
               if (dy_q == ow_q - 4'd1) begin
                  dy_d = '0;
                  if (nw_q != '0) state_d = S_DRAW;
                  else begin
                     state_d   = S_IDLE;
                     shadow_wr = 1'b1;
                  end
               end else begin
                  dy_d = dy_q + 4'd1;
               end
            end else begin
               dx_d = dx_q + 4'd1;
            end
         end
         S_DRAW: begin
            if (dx_q == nw_q - 4'd1) begin
               dx_d = '0;
               if (dy_q == nw_q - 4'd1) begin
                  dy_d      = '0;
                  state_d   = S_IDLE;
                  shadow_wr = 1'b1;
               end else begin
                  dy_d = dy_q + 4'd1;
               end
            end else begin
               dx_d = dx_q + 4'd1;
            end
         end
      endcase

      if (shadow_wr) begin
         old_x_d[sel_q] = nx_d;
         old_y_d[sel_q] = ny_d;
         old_w_d[sel_q] = nw_d;
      end

      if (clear_all) begin
         state_d   = S_IDLE;
         pending_d = '0;
         dx_d      = '0;
         dy_d      = '0;
         old_x_d   = '{default: '0};
         old_y_d   = '{default: '0};
         old_w_d   = '{default: '0};
      end
   end

   // Next-cycle pixel: computed from next state so the registered outputs line up with it
   always_comb begin
      sx       = '0;
      sy       = '0;
      pix_on   = 1'b0;
      vga_x_d  = '0;
      vga_y_d  = '0;
      colour_d = BG_COLOUR;
      plot_d   = 1'b0;
      busy_d   = (state_d != S_IDLE);

      case (state_d)
         S_ERASE: begin
            sx     = (XW+1)'(ox_d) + (XW+1)'(dx_d);
            sy     = (YW+1)'(oy_d) + (YW+1)'(dy_d);
            pix_on = 1'b1;
         end
         S_DRAW: begin
            sx     = (XW+1)'(nx_d) + (XW+1)'(dx_d);
            sy     = (YW+1)'(ny_d) + (YW+1)'(dy_d);
            pix_on = 1'b1;
            case (sel_d)
               2'd0:    colour_d = PLAYER_COLOUR;
               2'd1:    colour_d = BULLET_COLOUR;
               default: colour_d = ENEMY_COLOUR;
            endcase
         end
         default: ;
      endcase

      if (pix_on) begin
         vga_x_d = sx[XW-1:0];
         vga_y_d = sy[YW-1:0];
         plot_d  = (sx < (XW+1)'(SCREEN_W)) && (sy < (YW+1)'(SCREEN_H));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         sel_q     <= '0;
         ox_q      <= '0;
         oy_q      <= '0;
         ow_q      <= '0;
         nx_q      <= '0;
         ny_q      <= '0;
         nw_q      <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         old_x_q   <= '{default: '0};
         old_y_q   <= '{default: '0};
         old_w_q   <= '{default: '0};
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         colour_q  <= BG_COLOUR;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         sel_q     <= sel_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         ow_q      <= ow_d;
         nx_q      <= nx_d;
         ny_q      <= ny_d;
         nw_q      <= nw_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         old_x_q   <= old_x_d;
         old_y_q   <= old_y_d;
         old_w_q   <= old_w_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
      end
   end

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = colour_q;
   assign plot       = plot_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sprite_redraw.sv
// Directed bench for sprite_redraw: captures every plotted pixel per scenario
// and compares against hand-derived pixel lists, latencies and busy lengths.
module tb_sprite_redraw;

   logic       clk = 1'b0;
   logic       resetn;
   logic       clear_all;
   logic       p_move, b_move, e_move;
   logic [7:0] p_x, b_x, e_x;
   logic [6:0] p_y, b_y, e_y;
   logic [3:0] e_width;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       busy;

   int tests = 0;
   int fails = 0;

   int         n_plot, busy_cnt, first_t;
   logic [7:0] px [128];
   logic [6:0] py [128];
   logic [2:0] pc [128];
   int         pt [128];

   sprite_redraw dut (
      .clk(clk), .resetn(resetn), .clear_all(clear_all),
      .p_move(p_move), .p_x(p_x), .p_y(p_y),
      .b_move(b_move), .b_x(b_x), .b_y(b_y),
      .e_move(e_move), .e_x(e_x), .e_y(e_y), .e_width(e_width),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .plot(plot), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic start_capture();
      n_plot = 0; busy_cnt = 0; first_t = -1;
   endtask

   task automatic sample(input int t);
      if (busy === 1'b1) busy_cnt++;
      if (plot === 1'b1) begin
         if (n_plot < 128) begin
            px[n_plot] = vga_x; py[n_plot] = vga_y;
            pc[n_plot] = vga_colour; pt[n_plot] = t;
         end
         n_plot++;
         if (first_t < 0) first_t = t;
      end
   endtask

   // Pulse the selected move inputs for one cycle (t=0) and record ncyc further cycles
   task automatic run(input logic pm, input logic bm, input logic em, input int ncyc);
      start_capture();
      @(negedge clk);
      p_move = pm; b_move = bm; e_move = em;
      sample(0);
      for (int t = 1; t <= ncyc; t++) begin
         @(negedge clk);
         p_move = 1'b0; b_move = 1'b0; e_move = 1'b0;
         sample(t);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; clear_all = 1'b0;
      p_move = 1'b0; b_move = 1'b0; e_move = 1'b0;
      p_x = '0; p_y = '0; b_x = '0; b_y = '0; e_x = '0; e_y = '0; e_width = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'b000) begin
         fails++;
         $display("FAIL reset_outputs: got plot=%b busy=%b x=%0d y=%0d c=%b, want 0 0 0 0 000",
                  plot, busy, vga_x, vga_y, vga_colour);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0 || vga_colour !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset: got plot=%b busy=%b c=%b, want 0 0 000", plot, busy, vga_colour);
      end
   endtask

   task automatic test_fresh_draw();
      p_x = 8'd80; p_y = 7'd115;
      run(1'b1, 1'b0, 1'b0, 20);
      tests++;
      if (n_plot != 9 || busy_cnt != 10 || first_t != 3) begin
         fails++;
         $display("FAIL fresh_counts: got plots=%0d busy=%0d first=%0d, want 9 10 3", n_plot, busy_cnt, first_t);
      end
      for (int k = 0; k < 9; k++) begin
         tests++;
         if (px[k] !== 8'(80 + k % 3) || py[k] !== 7'(115 + k / 3) || pc[k] !== 3'b010) begin
            fails++;
            $display("FAIL fresh_pix%0d: got (%0d,%0d,%b), want (%0d,%0d,010)",
                     k, px[k], py[k], pc[k], 80 + k % 3, 115 + k / 3);
         end
      end
      tests++;
      if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'b000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL fresh_idle: got x=%0d y=%0d c=%b busy=%b, want 0 0 000 0", vga_x, vga_y, vga_colour, busy);
      end
   endtask

   task automatic test_move_left();
      p_x = 8'd79;
      run(1'b1, 1'b0, 1'b0, 30);
      tests++;
      if (n_plot != 18 || busy_cnt != 19) begin
         fails++;
         $display("FAIL move_counts: got plots=%0d busy=%0d, want 18 19", n_plot, busy_cnt);
      end
      for (int k = 0; k < 18; k++) begin
         tests++;
         if (k < 9) begin
            if (px[k] !== 8'(80 + k % 3) || py[k] !== 7'(115 + k / 3) || pc[k] !== 3'b000) begin
               fails++;
               $display("FAIL move_erase%0d: got (%0d,%0d,%b), want (%0d,%0d,000)",
                        k, px[k], py[k], pc[k], 80 + k % 3, 115 + k / 3);
            end
         end else if (px[k] !== 8'(79 + (k - 9) % 3) || py[k] !== 7'(115 + (k - 9) / 3) || pc[k] !== 3'b010) begin
            fails++;
            $display("FAIL move_draw%0d: got (%0d,%0d,%b), want (%0d,%0d,010)",
                     k, px[k], py[k], pc[k], 79 + (k - 9) % 3, 115 + (k - 9) / 3);
         end
      end
   endtask

   task automatic test_simultaneous();
      b_x = 8'd10; b_y = 7'd20;
      e_x = 8'd40; e_y = 7'd50; e_width = 4'd2;
      run(1'b1, 1'b1, 1'b1, 40);
      tests++;
      if (n_plot != 23 || busy_cnt != 26 || busy !== 1'b0) begin
         fails++;
         $display("FAIL simul_counts: got plots=%0d busy=%0d end_busy=%b, want 23 26 0", n_plot, busy_cnt, busy);
      end
      for (int k = 0; k < 18; k++) begin
         tests++;
         if (px[k] !== 8'(79 + (k % 9) % 3) || py[k] !== 7'(115 + (k % 9) / 3) ||
             pc[k] !== ((k < 9) ? 3'b000 : 3'b010)) begin
            fails++;
            $display("FAIL simul_player%0d: got (%0d,%0d,%b), want (%0d,%0d)",
                     k, px[k], py[k], pc[k], 79 + (k % 9) % 3, 115 + (k % 9) / 3);
         end
      end
      tests++;
      if (px[18] !== 8'd10 || py[18] !== 7'd20 || pc[18] !== 3'b111 || pt[18] != 23) begin
         fails++;
         $display("FAIL simul_bullet: got (%0d,%0d,%b) t=%0d, want (10,20,111) t=23", px[18], py[18], pc[18], pt[18]);
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (px[19+k] !== 8'(40 + k % 2) || py[19+k] !== 7'(50 + k / 2) || pc[19+k] !== 3'b100) begin
            fails++;
            $display("FAIL simul_enemy%0d: got (%0d,%0d,%b), want (%0d,%0d,100)",
                     k, px[19+k], py[19+k], pc[19+k], 40 + k % 2, 50 + k / 2);
         end
      end
      tests++;
      if (pt[19] != 26) begin
         fails++;
         $display("FAIL simul_enemy_time: got t=%0d, want 26", pt[19]);
      end
   endtask

   // Second pulse while busy queues one more job; third is coalesced; LOAD takes latest p_x
   task automatic test_back_to_back();
      start_capture();
      @(negedge clk);
      p_move = 1'b1;
      sample(0);
      for (int t = 1; t <= 50; t++) begin
         @(negedge clk);
         p_move = (t == 5 || t == 6);
         if (t == 10) p_x = 8'd70;
         sample(t);
      end
      tests++;
      if (n_plot != 36 || busy_cnt != 38 || pt[18] != 23 || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b_counts: got plots=%0d busy=%0d t18=%0d end_busy=%b, want 36 38 23 0",
                  n_plot, busy_cnt, pt[18], busy);
      end
      for (int k = 27; k < 36; k++) begin
         tests++;
         if (px[k] !== 8'(70 + (k - 27) % 3) || py[k] !== 7'(115 + (k - 27) / 3) || pc[k] !== 3'b010) begin
            fails++;
            $display("FAIL b2b_draw%0d: got (%0d,%0d,%b), want (%0d,%0d,010)",
                     k, px[k], py[k], pc[k], 70 + (k - 27) % 3, 115 + (k - 27) / 3);
         end
      end
      tests++;
      if (px[18] !== 8'd79 || pc[18] !== 3'b000) begin
         fails++;
         $display("FAIL b2b_erase: got (%0d,%b), want (79,000)", px[18], pc[18]);
      end
   endtask

   task automatic test_enemy_death();
      e_x = 8'd60; e_y = 7'd30; e_width = 4'd4;
      run(1'b0, 1'b0, 1'b1, 30);
      tests++;
      if (n_plot != 20 || busy_cnt != 21 || px[0] !== 8'd40 || pc[0] !== 3'b000 ||
          px[19] !== 8'd63 || py[19] !== 7'd33 || pc[19] !== 3'b100) begin
         fails++;
         $display("FAIL grow: got plots=%0d busy=%0d first=(%0d,%b) last=(%0d,%0d,%b), want 20 21 (40,000) (63,33,100)",
                  n_plot, busy_cnt, px[0], pc[0], px[19], py[19], pc[19]);
      end
      e_width = 4'd0;
      run(1'b0, 1'b0, 1'b1, 25);
      tests++;
      if (n_plot != 16 || busy_cnt != 17) begin
         fails++;
         $display("FAIL death_counts: got plots=%0d busy=%0d, want 16 17", n_plot, busy_cnt);
      end
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (px[k] !== 8'(60 + k % 4) || py[k] !== 7'(30 + k / 4) || pc[k] !== 3'b000) begin
            fails++;
            $display("FAIL death_pix%0d: got (%0d,%0d,%b), want (%0d,%0d,000)",
                     k, px[k], py[k], pc[k], 60 + k % 4, 30 + k / 4);
         end
      end
      run(1'b0, 1'b0, 1'b1, 8);
      tests++;
      if (n_plot != 0 || busy_cnt != 1) begin
         fails++;
         $display("FAIL dead_again: got plots=%0d busy=%0d, want 0 1", n_plot, busy_cnt);
      end
   endtask

   task automatic test_edge_clip();
      e_x = 8'd158; e_y = 7'd10; e_width = 4'd4;
      run(1'b0, 1'b0, 1'b1, 25);
      tests++;
      if (n_plot != 8 || busy_cnt != 17 || first_t != 3 || pt[2] != 7) begin
         fails++;
         $display("FAIL clip_counts: got plots=%0d busy=%0d first=%0d t2=%0d, want 8 17 3 7",
                  n_plot, busy_cnt, first_t, pt[2]);
      end
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (px[k] !== 8'(158 + k % 2) || py[k] !== 7'(10 + k / 2) || pc[k] !== 3'b100) begin
            fails++;
            $display("FAIL clip_pix%0d: got (%0d,%0d,%b), want (%0d,%0d,100)",
                     k, px[k], py[k], pc[k], 158 + k % 2, 10 + k / 2);
         end
      end
   endtask

   task automatic test_clear_all();
      start_capture();
      @(negedge clk);
      p_move = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         p_move = 1'b0;
      end
      clear_all = 1'b1; b_move = 1'b1;
      @(negedge clk);
      clear_all = 1'b0; b_move = 1'b0;
      tests++;
      if (busy !== 1'b0 || plot !== 1'b0 || vga_x !== 8'd0) begin
         fails++;
         $display("FAIL clear_abort: got busy=%b plot=%b x=%0d, want 0 0 0", busy, plot, vga_x);
      end
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         sample(t);
      end
      tests++;
      if (busy_cnt != 0) begin
         fails++;
         $display("FAIL clear_priority: got busy cycles=%0d, want 0", busy_cnt);
      end
      p_x = 8'd90; p_y = 7'd5;
      run(1'b1, 1'b0, 1'b0, 20);
      tests++;
      if (n_plot != 9 || busy_cnt != 10 || pc[0] !== 3'b010 || px[0] !== 8'd90 || py[0] !== 7'd5) begin
         fails++;
         $display("FAIL clear_redraw: got plots=%0d busy=%0d first=(%0d,%0d,%b), want 9 10 (90,5,010)",
                  n_plot, busy_cnt, px[0], py[0], pc[0]);
      end
   endtask

   task automatic test_reset_mid_draw();
      @(negedge clk);
      p_move = 1'b1;
      for (int t = 1; t <= 14; t++) begin
         @(negedge clk);
         p_move = 1'b0;
         b_move = (t == 13);
      end
      b_move = 1'b0;
      tests++;
      if (plot !== 1'b1 || vga_colour !== 3'b010) begin
         fails++;
         $display("FAIL mid_draw_setup: got plot=%b c=%b, want 1 010", plot, vga_colour);
      end
      resetn = 1'b0;
      #1;
      tests++;
      if (plot !== 1'b0 || busy !== 1'b0 || vga_colour !== 3'b000) begin
         fails++;
         $display("FAIL async_reset: got plot=%b busy=%b c=%b, want 0 0 000", plot, busy, vga_colour);
      end
      @(negedge clk);
      resetn = 1'b1;
      start_capture();
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         sample(t);
      end
      tests++;
      if (busy_cnt != 0) begin
         fails++;
         $display("FAIL reset_pending: got busy cycles=%0d, want 0", busy_cnt);
      end
      run(1'b1, 1'b0, 1'b0, 20);
      tests++;
      if (n_plot != 9 || busy_cnt != 10 || pc[0] !== 3'b010) begin
         fails++;
         $display("FAIL reset_redraw: got plots=%0d busy=%0d c=%b, want 9 10 010", n_plot, busy_cnt, pc[0]);
      end
      e_width = 4'd0;
      run(1'b0, 1'b0, 1'b1, 8);
      tests++;
      if (n_plot != 0 || busy_cnt != 1) begin
         fails++;
         $display("FAIL reset_enemy_shadow: got plots=%0d busy=%0d, want 0 1", n_plot, busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fresh_draw();
      test_move_left();
      test_simultaneous();
      test_back_to_back();
      test_enemy_death();
      test_edge_clip();
      test_clear_all();
      test_reset_mid_draw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
